// File: rtl/cmpr_eq_arbiter_if.sv
// Request/response bundle for the shared equality-compare slot.
// Handshake: a transfer happens on a rising edge where valid && ready; valid never waits on ready.
interface cmpr_eq_arbiter_if #(
    parameter int WIDTH   = 4,
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*WIDTH-1:0] req_i0;
    logic [NUM_REQ*WIDTH-1:0] req_i1;
    logic [NUM_REQ-1:0]       req_pred;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [ID_W-1:0]          rsp_id;
    logic [WIDTH-1:0]         rsp_o0;
    logic                     rsp_o0_enable;

    modport master (
        output req_valid, req_i0, req_i1, req_pred, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_o0, rsp_o0_enable
    );

    modport slave (
        input  req_valid, req_i0, req_i1, req_pred, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_o0, rsp_o0_enable
    );
endinterface

// File: rtl/cmpr_eq_arbiter.sv
// Round-robin arbiter feeding one shared equality comparator through a
// two-stage (operand register, response register) pipeline with backpressure.
module cmpr_eq_arbiter #(
    parameter int WIDTH   = 4,
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input logic               clk,
    input logic               reset,
    cmpr_eq_arbiter_if.slave  bus
);
    logic             a_valid_q, a_valid_d;
    logic [WIDTH-1:0] a_i0_q, a_i0_d;
    logic [WIDTH-1:0] a_i1_q, a_i1_d;
    logic             a_pred_q, a_pred_d;
    logic [ID_W-1:0]  a_id_q, a_id_d;
    logic [ID_W-1:0]  rr_q, rr_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]  rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0] rsp_o0_q, rsp_o0_d;
    logic             rsp_en_q, rsp_en_d;

    logic               b_free, a_move, a_free, found, grant_fire;
    logic [NUM_REQ-1:0] hi_mask, masked, cand, grant_oh;
    logic [ID_W-1:0]    grant_id;
    logic [WIDTH-1:0]   sel_i0, sel_i1;
    logic               sel_pred;

    assign b_free     = !rsp_valid_q || bus.rsp_ready;
    assign a_move     = a_valid_q && b_free;
    assign a_free     = !a_valid_q || b_free;
    assign grant_fire = a_free && found && !reset;

    // Requesters at or above the pointer win first; otherwise wrap to the lowest index.
    always_comb begin
        hi_mask = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            hi_mask[k] = (ID_W'(k) >= rr_q);
        end
        masked   = bus.req_valid & hi_mask;
        cand     = (|masked) ? masked : bus.req_valid;
        found    = |cand;
        grant_id = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (cand[k]) grant_id = ID_W'(k);
        end
    end

    always_comb begin
        grant_oh = '0;
        sel_i0   = '0;
        sel_i1   = '0;
        sel_pred = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            grant_oh[k] = grant_fire && (ID_W'(k) == grant_id);
            if (ID_W'(k) == grant_id) begin
                sel_i0   = bus.req_i0[k*WIDTH +: WIDTH];
                sel_i1   = bus.req_i1[k*WIDTH +: WIDTH];
                sel_pred = bus.req_pred[k];
            end
        end
    end

    always_comb begin
        a_valid_d   = a_valid_q;
        a_i0_d      = a_i0_q;
        a_i1_d      = a_i1_q;
        a_pred_d    = a_pred_q;
        a_id_d      = a_id_q;
        rr_d        = rr_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_o0_d    = rsp_o0_q;
        rsp_en_d    = rsp_en_q;

        if (a_move) a_valid_d = 1'b0;
        if (grant_fire) begin
            a_valid_d = 1'b1;
            a_i0_d    = sel_i0;
            a_i1_d    = sel_i1;
            a_pred_d  = sel_pred;
            a_id_d    = grant_id;
            rr_d      = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
        end

        // A free response slot always takes whatever stage A holds, including nothing.
        if (b_free) begin
            rsp_valid_d = a_valid_q;
            if (a_valid_q) begin
                rsp_id_d    = a_id_q;
                rsp_o0_d    = '0;
                rsp_o0_d[0] = (a_i0_q == a_i1_q);
                rsp_en_d    = a_pred_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_valid_q   <= 1'b0;
            a_i0_q      <= '0;
            a_i1_q      <= '0;
            a_pred_q    <= 1'b0;
            a_id_q      <= '0;
            rr_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_o0_q    <= '0;
            rsp_en_q    <= 1'b0;
        end else begin
            a_valid_q   <= a_valid_d;
            a_i0_q      <= a_i0_d;
            a_i1_q      <= a_i1_d;
            a_pred_q    <= a_pred_d;
            a_id_q      <= a_id_d;
            rr_q        <= rr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_o0_q    <= rsp_o0_d;
            rsp_en_q    <= rsp_en_d;
        end
    end

    assign bus.req_ready     = grant_oh;
    assign bus.rsp_valid     = rsp_valid_q;
    assign bus.rsp_id        = rsp_id_q;
    assign bus.rsp_o0        = rsp_o0_q;
    assign bus.rsp_o0_enable = rsp_en_q;
endmodule

// File: tb/tb_cmpr_eq_arbiter.sv
// Bench for cmpr_eq_arbiter: directed scenarios followed by random traffic,
// all checked against an in-order response queue with a two-entry capacity rule.
module tb_cmpr_eq_arbiter;
    localparam int WIDTH   = 4;
    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;
    localparam int EW      = ID_W + WIDTH + 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    cmpr_eq_arbiter_if #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

    cmpr_eq_arbiter #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Expected responses in grant order: {id, o0, enable}, plus the cycle each was granted.
    logic [EW-1:0] exp_q[$];
    int            acc_q[$];
    int            rr_m, cyc, rst_edges, n_cmp, n_err, dut_acc;
    logic [NUM_REQ-1:0] acc_mask, samp_rdy;
    logic               samp_valid, samp_en;
    logic [ID_W-1:0]    samp_id;
    logic [WIDTH-1:0]   samp_o0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int k, input logic v, input logic [WIDTH-1:0] i0,
                           input logic [WIDTH-1:0] i1, input logic p);
        bus.req_valid[k]                = v;
        bus.req_i0[k*WIDTH +: WIDTH]    = i0;
        bus.req_i1[k*WIDTH +: WIDTH]    = i1;
        bus.req_pred[k]                 = p;
    endtask

    // One clock: sample at the falling edge, compare with the model, advance the model.
    task automatic step();
        logic               vis;
        int                 gnt;
        logic [NUM_REQ-1:0] exp_rdy;
        logic [EW-1:0]      head;
        logic [WIDTH-1:0]   a, b;
        @(negedge clk);
        samp_rdy   = bus.req_ready;
        samp_valid = bus.rsp_valid;
        samp_id    = bus.rsp_id;
        samp_o0    = bus.rsp_o0;
        samp_en    = bus.rsp_o0_enable;
        acc_mask   = bus.req_valid & bus.req_ready;
        dut_acc    = dut_acc + $countones(acc_mask);
        gnt        = -1;
        if (reset) begin
            chk("rst_req_ready", samp_rdy, '0);
            if (rst_edges > 0) begin
                chk("rst_rsp_valid", samp_valid, 0);
                chk("rst_rsp_id", samp_id, 0);
                chk("rst_rsp_o0", samp_o0, 0);
                chk("rst_rsp_en", samp_en, 0);
            end
            exp_q.delete();
            acc_q.delete();
            rr_m = 0;
            rst_edges++;
        end else begin
            rst_edges = 0;
            vis = 1'b0;
            if (exp_q.size() > 0) vis = (acc_q[0] + 2 <= cyc);
            chk("rsp_valid", samp_valid, vis);
            if (vis) begin
                head = exp_q[0];
                chk("rsp_id", samp_id, head[EW-1 -: ID_W]);
                chk("rsp_o0", samp_o0, head[WIDTH:1]);
                chk("rsp_en", samp_en, head[0]);
            end
            if ((exp_q.size() - ((vis && bus.rsp_ready) ? 1 : 0)) < 2) begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    int k;
                    k = (rr_m + i) % NUM_REQ;
                    if (gnt < 0 && bus.req_valid[k]) gnt = k;
                end
            end
            exp_rdy = '0;
            if (gnt >= 0) exp_rdy[gnt] = 1'b1;
            chk("req_ready", samp_rdy, exp_rdy);
            if (vis && bus.rsp_ready) begin
                void'(exp_q.pop_front());
                void'(acc_q.pop_front());
            end
            if (gnt >= 0) begin
                a = bus.req_i0[gnt*WIDTH +: WIDTH];
                b = bus.req_i1[gnt*WIDTH +: WIDTH];
                exp_q.push_back({ID_W'(gnt), WIDTH'(a == b), bus.req_pred[gnt]});
                acc_q.push_back(cyc);
                rr_m = (gnt + 1) % NUM_REQ;
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset         = 1'b1;
        bus.req_valid = '0;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        n_cmp = 0; n_err = 0; cyc = 0; rst_edges = 0; rr_m = 0; dut_acc = 0;
        acc_mask = '0;
        reset = 1'b1;
        bus.req_valid = '0; bus.req_i0 = '0; bus.req_i1 = '0; bus.req_pred = '0;
        bus.rsp_ready = 1'b1;
        do_reset();

        // Single matching request with pred high.
        set_req(2, 1'b1, 4'hA, 4'hA, 1'b1);
        step();
        chk("t1_ready", samp_rdy, 4'b0100);
        bus.req_valid = '0;
        step();
        step();
        chk("t1_valid", samp_valid, 1);
        chk("t1_id", samp_id, 2);
        chk("t1_o0", samp_o0, 4'h1);
        chk("t1_en", samp_en, 1);

        // Mismatch with pred low.
        set_req(1, 1'b1, 4'h3, 4'h5, 1'b0);
        step();
        bus.req_valid = '0;
        step();
        step();
        chk("t2_valid", samp_valid, 1);
        chk("t2_id", samp_id, 1);
        chk("t2_o0", samp_o0, 4'h0);
        chk("t2_en", samp_en, 0);

        // All requesters held valid: strict rotation, no bubbles.
        do_reset();
        for (int k = 0; k < NUM_REQ; k++) set_req(k, 1'b1, 4'(k), 4'(3 - k), 1'b1);
        for (int i = 0; i < 7; i++) begin
            step();
            chk("fair_grant", samp_rdy, NUM_REQ'(1) << (i % NUM_REQ));
            if (i >= 2) begin
                chk("fair_rsp_valid", samp_valid, 1);
                chk("fair_rsp_id", samp_id, (i - 2) % NUM_REQ);
            end
        end

        // Backpressure: two accepts fill the pipe, then everything holds.
        do_reset();
        bus.rsp_ready = 1'b0;
        set_req(0, 1'b1, 4'h7, 4'h7, 1'b1);
        set_req(3, 1'b1, 4'h2, 4'h9, 1'b0);
        dut_acc = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (i >= 2) begin
                chk("bp_hold_valid", samp_valid, 1);
                chk("bp_hold_id", samp_id, 0);
                chk("bp_hold_o0", samp_o0, 1);
            end
        end
        chk("bp_accepts", dut_acc, 2);
        chk("bp_ready_zero", samp_rdy, 0);
        bus.rsp_ready = 1'b1;
        step();
        chk("bp_rel_id0", samp_id, 0);
        chk("bp_rel_grant", samp_rdy, 4'b0001);
        step();
        chk("bp_rel_id3", samp_id, 3);
        chk("bp_rel_o0", samp_o0, 0);

        // Reset with both stages full.
        bus.rsp_ready = 1'b0;
        step();
        step();
        step();
        reset = 1'b1;
        step();
        step();
        chk("mr_valid", samp_valid, 0);
        chk("mr_ready", samp_rdy, 0);
        reset = 1'b0;
        bus.rsp_ready = 1'b1;
        bus.req_valid = 4'b0110;
        step();
        chk("mr_first", samp_rdy, 4'b0010);

        // Pointer wrap from 3 to 0.
        do_reset();
        set_req(2, 1'b1, 4'h1, 4'h1, 1'b1);
        step();
        bus.req_valid = 4'b1001;
        step();
        chk("wrap_3", samp_rdy, 4'b1000);
        step();
        chk("wrap_0", samp_rdy, 4'b0001);

        // Random traffic with random backpressure and occasional reset.
        bus.req_valid = '0;
        for (int i = 0; i < 500; i++) begin
            logic [WIDTH-1:0] ra, rb;
            reset         = ($urandom_range(0, 149) == 0);
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < NUM_REQ; k++) begin
                if (!(bus.req_valid[k] && !acc_mask[k])) begin
                    ra = WIDTH'($urandom);
                    rb = ($urandom_range(0, 1) == 0) ? ra : WIDTH'($urandom);
                    set_req(k, ($urandom_range(0, 9) < 6), ra, rb, 1'($urandom));
                end
            end
            step();
        end
        reset = 1'b0;
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();
        chk("drain_empty", samp_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
